// File: rtl/fsm_experiment_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | fsm_experiment_seq : shot sequencer (fg sync, delay, staggered channel pulses, wire, det)  |
// | Optional: FSM_EXP_TIMESTAMP_EN adds shot_time output.            Rev 1.0 - initial release |
// +--------------------------------------------------------------------------------------------+
module fsm_experiment_seq #(
  parameter int CH                     = 4,
  parameter int CNT_W                  = 32,
  parameter int FG_DELAY               = 100_000,
  parameter int DET_PULSE              = 50,
  parameter int WIRE_TIMEOUT           = 350_000,
  parameter int DETECTOR_READY_TIMEOUT = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_signal,
  input  logic             abort,
  input  logic             fault_clear,
  input  logic [CH-1:0]    ch_enable,
  input  logic [CNT_W-1:0] stagger,
  input  logic             fg_signal,
  input  logic             wire_signal,
  input  logic             detector_ready,
  output logic [CH-1:0]    detonation_signal,
  output logic             output_trigger,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code
`ifdef FSM_EXP_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0] shot_time
`endif
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FG_WAIT   = 4'd1,
    S_FG_DLY    = 4'd2,
    S_DET_PULSE = 4'd3,
    S_DET_GAP   = 4'd4,
    S_WIRE_WAIT = 4'd5,
    S_DET_WAIT  = 4'd6,
    S_DONE      = 4'd7,
    S_FAULT     = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] c_fg_last    = CNT_W'(FG_DELAY - 1);
  localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(DET_PULSE - 1);
  localparam logic [CNT_W-1:0] c_wire_last  = CNT_W'(WIRE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_ready_last = CNT_W'(DETECTOR_READY_TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] stagger_q;
  logic [CH-1:0]    rem_q;
  logic [CH-1:0]    det_q;
  logic             trig_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;
  logic [1:0]       code_q;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [CH-1:0]    w_pick;
  logic [CH-1:0]    w_rem_rest;
  logic             w_busy_state;

  // Lowest set bit of the remaining mask; disabled channels cost no cycles.
  assign w_pick       = rem_q & (~rem_q + CH'(1));
  assign w_rem_rest   = rem_q & ~w_pick;
  assign w_cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign w_busy_state = (state_q != S_IDLE) && (state_q != S_FAULT);

`ifdef FSM_EXP_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_q;
  logic [CNT_W-1:0] shot_time_q;
  assign shot_time = shot_time_q;

  // ts_q is 1 on the first pulse's rising edge, so it reads the elapsed edge count directly.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ts_q        <= '0;
      shot_time_q <= '0;
    end else if (state_q == S_FG_DLY && cnt_q >= c_fg_last && !abort) begin
      ts_q        <= CNT_W'(1);
      shot_time_q <= '0;
    end else begin
      ts_q <= (ts_q == '1) ? ts_q : ts_q + CNT_W'(1);
      if (state_q == S_WIRE_WAIT && wire_signal && !abort) shot_time_q <= ts_q;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      stagger_q <= '0;
      rem_q     <= '0;
      det_q     <= '0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      done_q <= 1'b0;
      if (w_busy_state && abort) begin
        state_q <= S_FAULT;
        cnt_q   <= '0;
        det_q   <= '0;
        trig_q  <= 1'b0;
        busy_q  <= 1'b0;
        fault_q <= 1'b1;
        code_q  <= 2'd2;
      end else begin
        cnt_q <= w_cnt_inc;
        case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
            if (start_signal) begin
              stagger_q <= stagger;
              rem_q     <= ch_enable;
              if (ch_enable == '0) begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
                code_q  <= 2'd3;
              end else begin
                state_q <= S_FG_WAIT;
                busy_q  <= 1'b1;
              end
            end
          end
          S_FG_WAIT: begin
            cnt_q <= '0;
            if (fg_signal) state_q <= S_FG_DLY;
          end
          S_FG_DLY: begin
            if (cnt_q >= c_fg_last) begin
              state_q <= S_DET_PULSE;
              cnt_q   <= '0;
              det_q   <= w_pick;
              rem_q   <= w_rem_rest;
            end
          end
          S_DET_PULSE: begin
            if (cnt_q >= c_pulse_last) begin
              cnt_q <= '0;
              if (rem_q == '0) begin
                state_q <= S_WIRE_WAIT;
                det_q   <= '0;
              end else if (stagger_q == '0) begin
                det_q <= w_pick;
                rem_q <= w_rem_rest;
              end else begin
                state_q <= S_DET_GAP;
                det_q   <= '0;
              end
            end
          end
          S_DET_GAP: begin
            if (cnt_q >= stagger_q - CNT_W'(1)) begin
              state_q <= S_DET_PULSE;
              cnt_q   <= '0;
              det_q   <= w_pick;
              rem_q   <= w_rem_rest;
            end
          end
          S_WIRE_WAIT: begin
            if (wire_signal) begin
              state_q <= S_DET_WAIT;
              cnt_q   <= '0;
              trig_q  <= 1'b1;
            end else if (cnt_q >= c_wire_last) begin
              state_q <= S_FAULT;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              fault_q <= 1'b1;
              code_q  <= 2'd1;
            end
          end
          S_DET_WAIT: begin
            if (detector_ready || cnt_q >= c_ready_last) begin
              state_q <= S_DONE;
              cnt_q   <= '0;
              trig_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
          S_FAULT: begin
            cnt_q <= '0;
            if (fault_clear) begin
              state_q <= S_IDLE;
              fault_q <= 1'b0;
              code_q  <= 2'd0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            det_q   <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 2'd0;
          end
        endcase
      end
    end
  end

  assign detonation_signal = det_q;
  assign output_trigger    = trig_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign fault             = fault_q;
  assign fault_code        = code_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_experiment_seq.sv
`default_nettype none
// Directed bench for fsm_experiment_seq: per-cycle expected output vectors through a scoreboard queue.
module tb_fsm_experiment_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_signal = 1'b0;
  logic        abort = 1'b0;
  logic        fault_clear = 1'b0;
  logic [3:0]  ch_enable = 4'd0;
  logic [31:0] stagger = 32'd0;
  logic        fg_signal = 1'b0;
  logic        wire_signal = 1'b0;
  logic        detector_ready = 1'b0;
  logic [3:0]  detonation_signal;
  logic        output_trigger, busy, done, fault;
  logic [1:0]  fault_code;
`ifdef FSM_EXP_TIMESTAMP_EN
  logic [31:0] shot_time;
`endif

  fsm_experiment_seq #(
    .CH(4), .CNT_W(32), .FG_DELAY(10), .DET_PULSE(3),
    .WIRE_TIMEOUT(50), .DETECTOR_READY_TIMEOUT(5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_signal(start_signal), .abort(abort),
    .fault_clear(fault_clear), .ch_enable(ch_enable), .stagger(stagger),
    .fg_signal(fg_signal), .wire_signal(wire_signal), .detector_ready(detector_ready),
    .detonation_signal(detonation_signal), .output_trigger(output_trigger), .busy(busy),
    .done(done), .fault(fault), .fault_code(fault_code)
`ifdef FSM_EXP_TIMESTAMP_EN
    , .shot_time(shot_time)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] obs;
  assign obs = {detonation_signal, output_trigger, busy, done, fault, fault_code};

  function automatic logic [9:0] ev(input logic [3:0] d, input logic t, input logic b,
                                    input logic dn, input logic f, input logic [1:0] c);
    return {d, t, b, dn, f, c};
  endfunction

  task automatic tick(input string tag, input logic [9:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    n_cmp++;
    assert (obs === x.exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.exp);
    end
  endtask

  task automatic launch(input logic [3:0] m, input logic [31:0] stg);
    start_signal = 1'b1;
    ch_enable    = m;
    stagger      = stg;
    tick("start", ev(4'd0, 0, 1, 0, 0, 2'd0));
    start_signal = 1'b0;
    ch_enable    = 4'd0;
    tick("fg_wait", ev(4'd0, 0, 1, 0, 0, 2'd0));
    fg_signal = 1'b1;
    tick("fg_sample", ev(4'd0, 0, 1, 0, 0, 2'd0));
    fg_signal = 1'b0;
    repeat (9) tick("fg_delay", ev(4'd0, 0, 1, 0, 0, 2'd0));
  endtask

  task automatic pulses(input logic [3:0] m, input int stg);
    int         left;
    logic [3:0] oh;
    left = $countones(m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        oh = 4'b0001 << i;
        repeat (3) tick("pulse", ev(oh, 0, 1, 0, 0, 2'd0));
        left--;
        if (left > 0) repeat (stg) tick("gap", ev(4'd0, 0, 1, 0, 0, 2'd0));
      end
    end
  endtask

  // Wire sampled n edges after the edge that ended the last pulse.
  task automatic wire_at(input int n);
    tick("wire_wait", ev(4'd0, 0, 1, 0, 0, 2'd0));
    repeat (n - 1) tick("wire_wait", ev(4'd0, 0, 1, 0, 0, 2'd0));
    wire_signal = 1'b1;
    tick("trigger_on", ev(4'd0, 1, 1, 0, 0, 2'd0));
    wire_signal = 1'b0;
  endtask

  task automatic ready_timeout_finish();
    repeat (4) tick("trigger_hold", ev(4'd0, 1, 1, 0, 0, 2'd0));
    tick("done", ev(4'd0, 0, 1, 1, 0, 2'd0));
    tick("idle_after_done", ev(4'd0, 0, 0, 0, 0, 2'd0));
  endtask

  task automatic clear_fault();
    fault_clear = 1'b1;
    tick("fault_clear", ev(4'd0, 0, 0, 0, 0, 2'd0));
    fault_clear = 1'b0;
  endtask

  initial begin
    tick("reset", ev(4'd0, 0, 0, 0, 0, 2'd0));
    tick("reset", ev(4'd0, 0, 0, 0, 0, 2'd0));
    reset_n = 1'b1;
    tick("idle", ev(4'd0, 0, 0, 0, 0, 2'd0));
    abort = 1'b1;
    tick("abort_in_idle", ev(4'd0, 0, 0, 0, 0, 2'd0));
    abort = 1'b0;

    // Full mask, stagger 2, wire 20 after last pulse, detector never ready.
    launch(4'b1111, 32'd2);
    pulses(4'b1111, 2);
    wire_at(20);
    ready_timeout_finish();

    // Sparse mask, back-to-back pulses, detector acknowledges.
    launch(4'b1010, 32'd0);
    pulses(4'b1010, 0);
    wire_at(5);
    detector_ready = 1'b1;
    tick("ready_ack", ev(4'd0, 0, 1, 1, 0, 2'd0));
    detector_ready = 1'b0;
    tick("idle_after_done", ev(4'd0, 0, 0, 0, 0, 2'd0));

    // No wire: timeout fault exactly 50 edges after last pulse.
    launch(4'b0001, 32'd0);
    pulses(4'b0001, 0);
    tick("wire_wait", ev(4'd0, 0, 1, 0, 0, 2'd0));
    repeat (49) tick("wire_wait", ev(4'd0, 0, 1, 0, 0, 2'd0));
    tick("wire_timeout", ev(4'd0, 0, 0, 0, 1, 2'd1));
    tick("fault_hold", ev(4'd0, 0, 0, 0, 1, 2'd1));
    clear_fault();

    // Abort during ch2 pulse.
    launch(4'b1111, 32'd0);
    pulses(4'b0011, 0);
    tick("pulse_ch2", ev(4'b0100, 0, 1, 0, 0, 2'd0));
    abort = 1'b1;
    tick("abort", ev(4'd0, 0, 0, 0, 1, 2'd2));
    abort = 1'b0;
    tick("fault_hold", ev(4'd0, 0, 0, 0, 1, 2'd2));
    clear_fault();

    // Empty mask faults immediately.
    start_signal = 1'b1;
    ch_enable    = 4'd0;
    tick("empty_mask", ev(4'd0, 0, 0, 0, 1, 2'd3));
    start_signal = 1'b0;
    clear_fault();

    // Reset in the middle of the fg delay.
    start_signal = 1'b1;
    ch_enable    = 4'b0100;
    tick("start", ev(4'd0, 0, 1, 0, 0, 2'd0));
    start_signal = 1'b0;
    fg_signal = 1'b1;
    tick("fg_sample", ev(4'd0, 0, 1, 0, 0, 2'd0));
    fg_signal = 1'b0;
    repeat (4) tick("fg_delay", ev(4'd0, 0, 1, 0, 0, 2'd0));
    reset_n = 1'b0;
    tick("mid_reset", ev(4'd0, 0, 0, 0, 0, 2'd0));
    reset_n = 1'b1;
    repeat (12) tick("idle_after_reset", ev(4'd0, 0, 0, 0, 0, 2'd0));

    // Stagger 0, wire 7 after last pulse: 12 pulse edges + 7 = 19.
    launch(4'b1111, 32'd0);
    pulses(4'b1111, 0);
    wire_at(7);
`ifdef FSM_EXP_TIMESTAMP_EN
    n_cmp++;
    assert (shot_time === 32'd19) else begin
      n_bad++;
      $error("FAIL shot_time observed=%0d expected=%0d", shot_time, 19);
    end
`endif
    ready_timeout_finish();

    // Wire arriving on the timeout edge still wins.
    launch(4'b1000, 32'd3);
    pulses(4'b1000, 3);
    wire_at(50);
    ready_timeout_finish();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
